adc_regbank: RTL and testbench

Parametrised control/status register bank for the ADC capture path. It provides:
- RW config registers with byte enables.
- Self-clearing command pulses.
- Per-channel coherent result snapshots.
- Sticky write-1-to-clear interrupt status with mask and a registered irq output.
- Configurable read latency.

It sits between the host bus bridge and the ADC/FIFO datapath, and scales to NUM_CH channels.

---
 rtl/adc_regbank.sv | 213 +++++++++++++++++++++
 tb/tb_adc_regbank.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_regbank.sv
// adc_regbank: control/status register bank for the ADC capture path.
// Define ADC_REGBANK_SNAP_CNT_EN to add the SNAP_CNT register at 0x34.
module adc_regbank #(
    parameter int NUM_CH = 4,
    parameter int RES_W  = 12,
    parameter int AW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    wr_en,
    input  logic [3:0]              be,
    input  logic [AW-1:0]           wr_addr,
    input  logic [31:0]             wdata,
    input  logic                    rd_en,
    input  logic [AW-1:0]           rd_addr,
    output logic [31:0]             rdata,
    output logic                    rd_rdy,
    output logic [31:0]             ctrl,
    output logic [RES_W-1:0]        thresh,
    output logic                    fifo_rd_en,
    output logic                    fifo_rst,
    output logic                    irq,
    input  logic [NUM_CH*RES_W-1:0] adc_result,
    input  logic [NUM_CH-1:0]       adc_valid,
    input  logic                    fifo_full,
    input  logic                    fifo_empty
);

    localparam logic [AW-1:0] A_CTRL = AW'(32'h00);
    localparam logic [AW-1:0] A_CMD  = AW'(32'h04);
    localparam logic [AW-1:0] A_STAT = AW'(32'h08);
    localparam logic [AW-1:0] A_MASK = AW'(32'h0C);
    localparam logic [AW-1:0] A_SNAP = AW'(32'h10);
    localparam logic [AW-1:0] A_THR  = AW'(32'h30);
    localparam logic [31:0]   STAT_MSK =
        32'h0003_0000 | ((32'h1 << NUM_CH) - 32'h1);

    logic [31:0]             ctrl_q, ctrl_d;
    logic [31:0]             mask_q, mask_d;
    logic [31:0]             stat_q, stat_d;
    logic [31:0]             stat_set, stat_clr;
    logic [RES_W-1:0]        thresh_q, thresh_d;
    logic                    irq_q, irq_d;
    logic                    fifo_rd_en_q, fifo_rd_en_d;
    logic                    fifo_rst_q, fifo_rst_d;
    logic                    snap_q, snap_d;
    logic [NUM_CH-1:0]       snap_val_q, snap_val_d;
    logic [NUM_CH*RES_W-1:0] snap_dat_q, snap_dat_d;
    logic                    full_q, full_p_q;
    logic                    empty_q, empty_p_q;
    logic                    rd_vld_q, rd_vld_d;
    logic [31:0]             rd_dat_q, rd_dat_d;
    logic [31:0]             rmux;
    logic [NUM_CH-1:0]       rd_snap;

    logic wr_ctrl, wr_cmd, wr_stat, wr_mask, wr_thr;

    assign wr_ctrl = wr_en && (wr_addr == A_CTRL);
    assign wr_cmd  = wr_en && (wr_addr == A_CMD) && be[0];
    assign wr_stat = wr_en && (wr_addr == A_STAT);
    assign wr_mask = wr_en && (wr_addr == A_MASK);
    assign wr_thr  = wr_en && (wr_addr == A_THR);

`ifdef ADC_REGBANK_SNAP_CNT_EN
    localparam logic [AW-1:0] A_CNT = AW'(32'h34);
    logic [15:0] snap_cnt_q, snap_cnt_d;
    logic        wr_cnt;

    assign wr_cnt = wr_en && (wr_addr == A_CNT) && be[0];

    // A clear that lands with a snap still counts that snap.
    always_comb begin
        snap_cnt_d = snap_cnt_q;
        if (wr_cnt) snap_cnt_d = 16'd0;
        if (snap_q) snap_cnt_d = wr_cnt ? 16'd1 : snap_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) snap_cnt_q <= 16'd0;
        else       snap_cnt_q <= snap_cnt_d;
    end
`endif

    always_comb begin
        ctrl_d   = ctrl_q;
        mask_d   = mask_q;
        thresh_d = thresh_q;
        for (int i = 0; i < 32; i++) begin
            if (wr_ctrl && be[i/8]) ctrl_d[i] = wdata[i];
            if (wr_mask && be[i/8]) mask_d[i] = wdata[i];
        end
        mask_d = mask_d & STAT_MSK;
        for (int i = 0; i < RES_W; i++) begin
            if (wr_thr && be[i/8]) thresh_d[i] = wdata[i];
        end
    end

    always_comb begin
        fifo_rd_en_d = wr_cmd && wdata[0];
        fifo_rst_d   = wr_cmd && wdata[1];
        snap_d       = wr_cmd && wdata[2];
    end

    // Set events override a same-cycle W1C on the same bit.
    always_comb begin
        stat_set = '0;
        stat_clr = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            stat_set[ch] = adc_valid[ch] &&
                (adc_result[ch*RES_W +: RES_W] > thresh_q);
        end
        stat_set[16] = full_q && !full_p_q;
        stat_set[17] = empty_q && !empty_p_q;
        for (int i = 0; i < 32; i++) begin
            stat_clr[i] = wr_stat && be[i/8] && wdata[i];
        end
        stat_d = ((stat_q & ~stat_clr) | stat_set) & STAT_MSK;
        irq_d  = |(stat_q & mask_q);
    end

    always_comb begin
        rmux    = '0;
        rd_snap = '0;
        if (rd_addr == A_CTRL) rmux = ctrl_q;
        if (rd_addr == A_STAT) rmux = stat_q;
        if (rd_addr == A_MASK) rmux = mask_q;
        if (rd_addr == A_THR)  rmux[RES_W-1:0] = thresh_q;
`ifdef ADC_REGBANK_SNAP_CNT_EN
        if (rd_addr == A_CNT)  rmux[15:0] = snap_cnt_q;
`endif
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (rd_addr == A_SNAP + AW'(4 * ch)) begin
                rmux[31]          = snap_val_q[ch];
                rmux[RES_W-1:0]   = snap_dat_q[ch*RES_W +: RES_W];
                rd_snap[ch]       = rd_en;
            end
        end
        rd_vld_d = rd_en;
        rd_dat_d = rd_en ? rmux : '0;
    end

    always_comb begin
        snap_dat_d = snap_q ? adc_result : snap_dat_q;
        snap_val_d = snap_q ? '1 : (snap_val_q & ~rd_snap);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ctrl_q       <= '0;
            mask_q       <= '0;
            stat_q       <= '0;
            thresh_q     <= '0;
            irq_q        <= 1'b0;
            fifo_rd_en_q <= 1'b0;
            fifo_rst_q   <= 1'b0;
            snap_q       <= 1'b0;
            snap_val_q   <= '0;
            snap_dat_q   <= '0;
            full_q       <= 1'b0;
            full_p_q     <= 1'b0;
            empty_q      <= 1'b0;
            empty_p_q    <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_dat_q     <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            mask_q       <= mask_d;
            stat_q       <= stat_d;
            thresh_q     <= thresh_d;
            irq_q        <= irq_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            fifo_rst_q   <= fifo_rst_d;
            snap_q       <= snap_d;
            snap_val_q   <= snap_val_d;
            snap_dat_q   <= snap_dat_d;
            full_q       <= fifo_full;
            full_p_q     <= full_q;
            empty_q      <= fifo_empty;
            empty_p_q    <= empty_q;
            rd_vld_q     <= rd_vld_d;
            rd_dat_q     <= rd_dat_d;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic        rd_vld2_q;
            logic [31:0] rd_dat2_q;
            always_ff @(posedge clk or negedge rstb) begin
                if (!rstb) begin
                    rd_vld2_q <= 1'b0;
                    rd_dat2_q <= '0;
                end else begin
                    rd_vld2_q <= rd_vld_q;
                    rd_dat2_q <= rd_dat_q;
                end
            end
            assign rd_rdy = rd_vld2_q;
            assign rdata  = rd_dat2_q;
        end else begin : g_lat1
            assign rd_rdy = rd_vld_q;
            assign rdata  = rd_dat_q;
        end
    endgenerate

    assign ctrl       = ctrl_q;
    assign thresh     = thresh_q;
    assign fifo_rd_en = fifo_rd_en_q;
    assign fifo_rst   = fifo_rst_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_adc_regbank.sv
// Bench for adc_regbank: RD_LAT=1 and RD_LAT=2 instances share stimulus;
// reads are scored against a queue of expected data and due cycles.
module tb_adc_regbank;

    localparam int NUM_CH = 4;
    localparam int RES_W  = 12;
    localparam int AW     = 16;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rstb;
    logic                    wr_en, rd_en;
    logic [3:0]              be;
    logic [AW-1:0]           wr_addr, rd_addr;
    logic [31:0]             wdata;
    logic [NUM_CH*RES_W-1:0] adc_result;
    logic [NUM_CH-1:0]       adc_valid;
    logic                    fifo_full, fifo_empty;

    logic [31:0]      rdata_a, rdata_b, ctrl_a, ctrl_b;
    logic             rd_rdy_a, rd_rdy_b;
    logic [RES_W-1:0] thresh_a, thresh_b;
    logic             fre_a, fre_b, frst_a, frst_b, irq_a, irq_b;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b1;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_regbank #(.NUM_CH(NUM_CH), .RES_W(RES_W), .AW(AW), .RD_LAT(1)) u_a (
        .clk(clk), .rstb(rstb), .wr_en(wr_en), .be(be),
        .wr_addr(wr_addr), .wdata(wdata), .rd_en(rd_en),
        .rd_addr(rd_addr), .rdata(rdata_a), .rd_rdy(rd_rdy_a),
        .ctrl(ctrl_a), .thresh(thresh_a), .fifo_rd_en(fre_a),
        .fifo_rst(frst_a), .irq(irq_a), .adc_result(adc_result),
        .adc_valid(adc_valid), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty)
    );

    adc_regbank #(.NUM_CH(NUM_CH), .RES_W(RES_W), .AW(AW), .RD_LAT(2)) u_b (
        .clk(clk), .rstb(rstb), .wr_en(wr_en), .be(be),
        .wr_addr(wr_addr), .wdata(wdata), .rd_en(rd_en),
        .rd_addr(rd_addr), .rdata(rdata_b), .rd_rdy(rd_rdy_b),
        .ctrl(ctrl_b), .thresh(thresh_b), .fifo_rd_en(fre_b),
        .fifo_rst(frst_b), .irq(irq_b), .adc_result(adc_result),
        .adc_valid(adc_valid), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty)
    );

    // Scoreboard: every cycle either the due read or an idle bus.
    always @(negedge clk) begin
        if (rstb && mon_en) begin
            checks++;
            if (qa.size() != 0 && qa[0].due == cyc) begin
                if (rd_rdy_a !== 1'b1 || rdata_a !== qa[0].data) begin
                    errors++;
                    $display("FAIL read_lat1 cyc=%0d got rdy=%b data=%h want %h",
                             cyc, rd_rdy_a, rdata_a, qa[0].data);
                end
                void'(qa.pop_front());
            end else if (rd_rdy_a !== 1'b0 || rdata_a !== 32'h0) begin
                errors++;
                $display("FAIL idle_lat1 cyc=%0d got rdy=%b data=%h want 0",
                         cyc, rd_rdy_a, rdata_a);
            end
            checks++;
            if (qb.size() != 0 && qb[0].due == cyc) begin
                if (rd_rdy_b !== 1'b1 || rdata_b !== qb[0].data) begin
                    errors++;
                    $display("FAIL read_lat2 cyc=%0d got rdy=%b data=%h want %h",
                             cyc, rd_rdy_b, rdata_b, qb[0].data);
                end
                void'(qb.pop_front());
            end else if (rd_rdy_b !== 1'b0 || rdata_b !== 32'h0) begin
                errors++;
                $display("FAIL idle_lat2 cyc=%0d got rdy=%b data=%h want 0",
                         cyc, rd_rdy_b, rdata_b);
            end
        end
    end

    function automatic void push(input logic [31:0] d);
        qa.push_back('{cyc + 1, d});
        qb.push_back('{cyc + 2, d});
    endfunction

    function automatic logic [NUM_CH*RES_W-1:0] pat(input int k);
        logic [NUM_CH*RES_W-1:0] v;
        for (int ch = 0; ch < NUM_CH; ch++)
            v[ch*RES_W +: RES_W] = RES_W'((k * 37 + ch * 211 + 5) % 4096);
        return v;
    endfunction

    task automatic wr(input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] b);
        wr_en = 1'b1; wr_addr = a; wdata = d; be = b;
        @(negedge clk);
        wr_en = 1'b0; be = 4'h0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] e);
        rd_en = 1'b1; rd_addr = a;
        push(e);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({rd_rdy_a, rd_rdy_b, fre_a, fre_b, frst_a, frst_b, irq_a, irq_b} !== 8'h0 ||
            rdata_a !== 0 || rdata_b !== 0 || ctrl_a !== 0 || ctrl_b !== 0 ||
            thresh_a !== 0 || thresh_b !== 0) begin
            errors++;
            $display("FAIL reset_outputs got ctrl=%h thr=%h rdata=%h want all 0",
                     ctrl_a, thresh_a, rdata_a);
        end
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        rd(16'h00, 32'h0);
        rd(16'h08, 32'h0);
    endtask

    task automatic test_ctrl;
        wr(16'h00, 32'hA5A5A5A5, 4'b0101);
        checks++;
        if (ctrl_a !== 32'h00A500A5) begin
            errors++;
            $display("FAIL ctrl_be0101 got %h want 00a500a5", ctrl_a);
        end
        rd(16'h00, 32'h00A500A5);
        wr(16'h00, 32'h5A5A5A5A, 4'b1010);
        checks++;
        if (ctrl_a !== 32'h5AA55AA5) begin
            errors++;
            $display("FAIL ctrl_be1010 got %h want 5aa55aa5", ctrl_a);
        end
        rd(16'h00, 32'h5AA55AA5);
    endtask

    task automatic test_cmd;
        wr(16'h04, 32'h3, 4'b0001);
        checks++;
        if (fre_a !== 1'b1 || frst_a !== 1'b1 || fre_b !== 1'b1) begin
            errors++;
            $display("FAIL cmd_pulse got rd_en=%b rst=%b want 1 1", fre_a, frst_a);
        end
        @(negedge clk);
        checks++;
        if (fre_a !== 1'b0 || frst_a !== 1'b0) begin
            errors++;
            $display("FAIL cmd_pulse_end got rd_en=%b rst=%b want 0 0", fre_a, frst_a);
        end
        wr(16'h04, 32'h3, 4'b1110);
        checks++;
        if (fre_a !== 1'b0 || frst_a !== 1'b0) begin
            errors++;
            $display("FAIL cmd_no_be0 got rd_en=%b rst=%b want 0 0", fre_a, frst_a);
        end
        rd(16'h04, 32'h0);
    endtask

    task automatic test_overrange;
        wr(16'h30, 32'hFFFF_F800, 4'b0011);
        checks++;
        if (thresh_a !== 12'h800) begin
            errors++;
            $display("FAIL thresh got %h want 800", thresh_a);
        end
        rd(16'h30, 32'h800);
        adc_result = '0;
        adc_result[RES_W +: RES_W] = 12'h801;
        adc_valid = 4'b0010;
        @(negedge clk);
        adc_valid = 4'b0000;
        rd(16'h08, 32'h2);
        wr(16'h08, 32'h2, 4'b0001);
        rd(16'h08, 32'h0);
        adc_result[RES_W +: RES_W] = 12'h800;
        adc_valid = 4'b0010;
        @(negedge clk);
        adc_result[RES_W +: RES_W] = 12'h801;
        adc_valid = 4'b0000;
        @(negedge clk);
        rd(16'h08, 32'h0);
        adc_valid = 4'b0010;
        @(negedge clk);
        adc_valid = 4'b0000;
        wr(16'h0C, 32'h2, 4'b0001);
        checks++;
        if (irq_a !== 1'b0) begin
            errors++;
            $display("FAIL irq_early got %b want 0", irq_a);
        end
        @(negedge clk);
        checks++;
        if (irq_a !== 1'b1 || irq_b !== 1'b1) begin
            errors++;
            $display("FAIL irq_set got %b want 1", irq_a);
        end
        wr_en = 1'b1; wr_addr = 16'h08; wdata = 32'h2; be = 4'b0001;
        adc_valid = 4'b0010;
        @(negedge clk);
        wr_en = 1'b0; be = 4'h0; adc_valid = 4'b0000;
        rd(16'h08, 32'h2);
        wr(16'h08, 32'h2, 4'b0001);
        wr(16'h0C, 32'hFFFFFFFF, 4'b1111);
        rd(16'h0C, 32'h0003000F);
        wr(16'h0C, 32'h0, 4'b1111);
        rd(16'h08, 32'h0);
    endtask

    task automatic test_snap;
        logic [NUM_CH*RES_W-1:0] v1, v2;
        adc_result = pat(0);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 16'h04; wdata = 32'h4; be = 4'b0001;
        adc_result = pat(1);
        @(negedge clk);
        wr_en = 1'b0; be = 4'h0;
        adc_result = pat(2);
        v1 = pat(2);
        @(negedge clk);
        adc_result = pat(3);
        @(negedge clk);
        adc_result = pat(4);
        for (int ch = 0; ch < NUM_CH; ch++)
            rd(16'(16'h10 + 4 * ch), 32'h80000000 | 32'(v1[ch*RES_W +: RES_W]));
        rd(16'h10, 32'(v1[RES_W-1:0]));
        adc_result = pat(7);
        v2 = pat(7);
        wr(16'h04, 32'h4, 4'b0001);
        rd(16'h14, 32'(v1[RES_W +: RES_W]));
        rd(16'h14, 32'h80000000 | 32'(v2[RES_W +: RES_W]));
        rd(16'h10, 32'h80000000 | 32'(v2[RES_W-1:0]));
`ifdef ADC_REGBANK_SNAP_CNT_EN
        rd(16'h34, 32'h2);
`else
        rd(16'h34, 32'h0);
`endif
        wr(16'h34, 32'hFFFF, 4'b1111);
        rd(16'h34, 32'h0);
    endtask

    task automatic test_back_to_back;
        rd(16'h00, 32'h5AA55AA5);
        rd(16'h30, 32'h800);
        rd(16'h0C, 32'h0);
        rd(16'h3C, 32'h0);
        wr_en = 1'b1; wr_addr = 16'h00; wdata = 32'h12345678; be = 4'hF;
        rd_en = 1'b1; rd_addr = 16'h00;
        push(32'h5AA55AA5);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; be = 4'h0;
        rd(16'h00, 32'h12345678);
        wr(16'h3C, 32'hFFFFFFFF, 4'hF);
        rd(16'h3C, 32'h0);
    endtask

    task automatic test_fifo;
        fifo_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_en = (i == 4); wr_addr = 16'h08;
            wdata = 32'h10000; be = 4'b0100;
            rd_en = (i == 3 || i == 8); rd_addr = 16'h08;
            if (i == 3) push(32'h10000);
            if (i == 8) push(32'h0);
            @(negedge clk);
        end
        wr_en = 1'b0; rd_en = 1'b0; be = 4'h0; fifo_full = 1'b0;
        fifo_empty = 1'b1;
        repeat (4) @(negedge clk);
        rd(16'h08, 32'h20000);
        wr(16'h08, 32'h20000, 4'b0100);
        rd(16'h08, 32'h0);
        fifo_empty = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        wr(16'h0C, 32'h1, 4'b0001);
        adc_result = '0;
        adc_result[RES_W-1:0] = 12'hFFF;
        adc_valid = 4'b0001;
        @(negedge clk);
        adc_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (irq_a !== 1'b1) begin
            errors++;
            $display("FAIL irq_pre_reset got %b want 1", irq_a);
        end
        mon_en = 1'b0;
        wr_en = 1'b1; wr_addr = 16'h04; wdata = 32'h3; be = 4'b0001;
        rd_en = 1'b1; rd_addr = 16'h00;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; be = 4'h0;
        rstb = 1'b0;
        #1;
        checks++;
        if ({rd_rdy_a, rd_rdy_b, fre_a, frst_a, irq_a, irq_b} !== 6'h0 ||
            rdata_a !== 0 || rdata_b !== 0 || ctrl_a !== 0 || thresh_a !== 0) begin
            errors++;
            $display("FAIL reset_mid got rdy=%b/%b fre=%b irq=%b ctrl=%h want 0",
                     rd_rdy_a, rd_rdy_b, fre_a, irq_a, ctrl_a);
        end
        @(negedge clk);
        rstb = 1'b1;
        qa.delete();
        qb.delete();
        @(negedge clk);
        mon_en = 1'b1;
        rd(16'h08, 32'h0);
        rd(16'h0C, 32'h0);
        rd(16'h10, 32'h0);
    endtask

    initial begin
        rstb = 1'b0; wr_en = 1'b0; rd_en = 1'b0; be = 4'h0;
        wr_addr = '0; rd_addr = '0; wdata = '0;
        adc_result = '0; adc_valid = '0;
        fifo_full = 1'b0; fifo_empty = 1'b0;
        test_reset;
        test_ctrl;
        test_cmd;
        test_overrange;
        test_snap;
        test_back_to_back;
        test_fifo;
        test_reset_mid;
        repeat (4) @(negedge clk);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending want 0", qa.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
